ce_phase_decoder: RTL and testbench

- Receiving end of the 24 MHz clock-enable strobe bus (ce12, ce6, ce3, ce3v, video_slice, pipe_ab, ce1m5).
- Reconstructs the generator's 6-bit phase counter from the strobes and locks onto it.
- Keeps a flywheel phase and flags any strobe that deviates from the canonical pattern.
- Sits in the clk24 domain beside the video/CPU pipeline; used as a runtime integrity monitor and as a phase source for blocks that need the full slot number.

---
 rtl/ce_bus_pkg.sv | 39 +++
 rtl/ce_pattern_encode.sv | 13 +
 rtl/ce_phase_decoder.sv | 145 ++++++++++++++
 tb/tb_ce_phase_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ce_bus_pkg.sv
// ce_bus_pkg -- shared definitions for the 24 MHz clock-enable strobe bus.
//   SLOT_W / CE_W : slot number width and strobe vector width
//   B_*           : bit positions of each strobe inside the 7-bit vector
//                   (order: ce12, ce6, ce3, ce3v, video_slice, pipe_ab, ce1m5)
//   dec_state_t   : phase decoder lock states
//   ce_encode()   : canonical slot -> strobe vector mapping
package ce_bus_pkg;

  localparam int SLOT_W = 6;
  localparam int CE_W   = 7;

  localparam int B_CE12    = 0;
  localparam int B_CE6     = 1;
  localparam int B_CE3     = 2;
  localparam int B_CE3V    = 3;
  localparam int B_VIDEO   = 4;
  localparam int B_PIPE_AB = 5;
  localparam int B_CE1M5   = 6;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } dec_state_t;

  function automatic logic [CE_W-1:0] ce_encode(input logic [SLOT_W-1:0] c);
    logic [CE_W-1:0] v;
    v            = '0;
    v[B_CE12]    = c[0];
    v[B_CE6]     = c[1] & c[0];
    v[B_CE3]     = c[2] & ~c[1] & c[0];
    v[B_CE3V]    = c[2] & c[1] & ~c[0];
    v[B_VIDEO]   = ~c[2];
    v[B_PIPE_AB] = c[5];
    v[B_CE1M5]   = c[3] & c[2] & ~c[1] & c[0];
    return v;
  endfunction

endpackage

// File: rtl/ce_pattern_encode.sv
// ce_pattern_encode -- combinational slot-to-strobe-vector mapping.
//   slot : 6-bit slot number
//   vec  : 7-bit canonical strobe vector for that slot
module ce_pattern_encode
  import ce_bus_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  output logic [CE_W-1:0]   vec
);

  assign vec = ce_encode(slot);

endmodule

// File: rtl/ce_phase_decoder.sv
// ce_phase_decoder -- recovers the 6-bit generator phase from the clock-enable
// strobe bus, locks onto it and flags strobes that leave the canonical pattern.
//   clk24, reset      : 24 MHz clock, async active-high reset
//   ce12..ce1m5       : strobe bus inputs (synchronous to clk24)
//   phase             : slot number of the previous-cycle sample
//   locked            : high while in LOCKED
//   err               : one-cycle pulse per mismatch while locked
//   err_count         : saturating count of mismatches while locked
//   ce_next           : predicted strobes for the next cycle, zero when unlocked
//                       (present only with CE_PHASE_DECODER_PREDICT_EN)
module ce_phase_decoder
  import ce_bus_pkg::*;
#(
  parameter int LOCK_CYCLES = 64,
  parameter int LOSS_ERRORS = 4,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk24,
  input  logic                reset,
  input  logic                ce12,
  input  logic                ce6,
  input  logic                ce3,
  input  logic                ce3v,
  input  logic                video_slice,
  input  logic                pipe_ab,
  input  logic                ce1m5,
  output logic [SLOT_W-1:0]   phase,
  output logic                locked,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_count
`ifdef CE_PHASE_DECODER_PREDICT_EN
  ,
  output logic [CE_W-1:0]     ce_next
`endif
);

  localparam int MW = $clog2(LOCK_CYCLES + 1);
  localparam int LW = $clog2(LOSS_ERRORS + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_CYCLES);
  localparam logic [LW-1:0] LOSS_N = LW'(LOSS_ERRORS);

  dec_state_t          state, state_n;
  logic [SLOT_W-1:0]   exp_q, exp_n, phase_n;
  logic [MW-1:0]       match_cnt, match_n;
  logic [LW-1:0]       miss_cnt, miss_n;
  logic [ERRCNT_W-1:0] cnt_n;
  logic                err_n;
  logic                prev_ab, hist_vld;
  logic [CE_W-1:0]     in_vec, exp_vec;
  logic                hit;

  assign in_vec[B_CE12]    = ce12;
  assign in_vec[B_CE6]     = ce6;
  assign in_vec[B_CE3]     = ce3;
  assign in_vec[B_CE3V]    = ce3v;
  assign in_vec[B_VIDEO]   = video_slice;
  assign in_vec[B_PIPE_AB] = pipe_ab;
  assign in_vec[B_CE1M5]   = ce1m5;

  ce_pattern_encode u_enc_cmp (.slot(exp_q), .vec(exp_vec));

  assign hit    = (in_vec == exp_vec);
  assign locked = (state == LOCKED);

`ifdef CE_PHASE_DECODER_PREDICT_EN
  logic [CE_W-1:0] pred_vec;
  ce_pattern_encode u_enc_pred (.slot(exp_q), .vec(pred_vec));
  assign ce_next = locked ? pred_vec : '0;
`endif

  always_comb begin
    state_n = state;
    exp_n   = exp_q;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    phase_n = phase;
    err_n   = 1'b0;
    cnt_n   = err_count;
    unique case (state)
      HUNT: begin
        // A pipe_ab transition marks slot 0 or 32; strobe content is not trusted yet.
        if (hist_vld && (pipe_ab != prev_ab)) begin
          phase_n = {pipe_ab, 5'b0};
          exp_n   = {pipe_ab, 5'b0} + SLOT_W'(1);
          match_n = MW'(1);
          state_n = VERIFY;
        end
      end
      VERIFY: begin
        phase_n = exp_q;
        exp_n   = exp_q + SLOT_W'(1);
        if (hit) begin
          match_n = match_cnt + MW'(1);
          if (match_n == LOCK_N) state_n = LOCKED;
        end else begin
          match_n = '0;
          state_n = HUNT;
        end
      end
      LOCKED: begin
        // Flywheel: expected keeps counting regardless of what the bus shows.
        phase_n = exp_q;
        exp_n   = exp_q + SLOT_W'(1);
        if (hit) begin
          miss_n = '0;
        end else begin
          err_n  = 1'b1;
          if (err_count != '1) cnt_n = err_count + ERRCNT_W'(1);
          miss_n = miss_cnt + LW'(1);
          if (miss_n == LOSS_N) begin
            miss_n  = '0;
            match_n = '0;
            state_n = HUNT;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      exp_q     <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      phase     <= '0;
      err       <= 1'b0;
      err_count <= '0;
      prev_ab   <= 1'b0;
      hist_vld  <= 1'b0;
    end else begin
      state     <= state_n;
      exp_q     <= exp_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      phase     <= phase_n;
      err       <= err_n;
      err_count <= cnt_n;
      prev_ab   <= pipe_ab;
      hist_vld  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ce_phase_decoder.sv
// tb_ce_phase_decoder -- directed/randomized bench for ce_phase_decoder with a
// behavioural lock-tracking model. Optional ce_next checks follow
// CE_PHASE_DECODER_PREDICT_EN.
module tb_ce_phase_decoder;

  localparam int LOCK  = 64;
  localparam int LOSS  = 4;
  localparam int ECW   = 8;

  logic           clk24 = 1'b0;
  logic           reset = 1'b1;
  logic [6:0]     drv   = '0;
  logic [5:0]     phase;
  logic           locked, err;
  logic [ECW-1:0] err_count;
`ifdef CE_PHASE_DECODER_PREDICT_EN
  logic [6:0]     ce_next;
`endif

  ce_phase_decoder #(.LOCK_CYCLES(LOCK), .LOSS_ERRORS(LOSS), .ERRCNT_W(ECW)) dut (
    .clk24(clk24), .reset(reset),
    .ce12(drv[0]), .ce6(drv[1]), .ce3(drv[2]), .ce3v(drv[3]),
    .video_slice(drv[4]), .pipe_ab(drv[5]), .ce1m5(drv[6]),
    .phase(phase), .locked(locked), .err(err), .err_count(err_count)
`ifdef CE_PHASE_DECODER_PREDICT_EN
    , .ce_next(ce_next)
`endif
  );

  always #5 clk24 = ~clk24;

  int total = 0;
  int bad   = 0;
  int g;                       // generator slot presented next

  // model state: mode 0 = searching, 1 = confirming, 2 = locked
  int m_mode, m_exp, m_run, m_miss, m_phase, m_err, m_cnt, m_prev, m_hv;

  function automatic logic [6:0] enc(input int c);
    logic [6:0] v;
    v[0] = (c % 2) == 1;
    v[1] = (c % 4) == 3;
    v[2] = (c % 8) == 5;
    v[3] = (c % 8) == 6;
    v[4] = (c % 8) < 4;
    v[5] = c >= 32;
    v[6] = (c % 16) == 13;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_phase = 0;
    m_err = 0; m_cnt = 0; m_prev = 0; m_hv = 0;
  endtask

  task automatic model_update(input logic [6:0] v);
    int ab;
    bit ok;
    ab = int'(v[5]);
    m_err = 0;
    if (m_mode == 0) begin
      if (m_hv == 1 && ab != m_prev) begin
        m_phase = ab * 32;
        m_exp   = (m_phase + 1) % 64;
        m_run   = 1;
        m_mode  = 1;
      end
    end else begin
      ok      = (v == enc(m_exp));
      m_phase = m_exp;
      m_exp   = (m_exp + 1) % 64;
      if (m_mode == 1) begin
        if (ok) begin
          m_run++;
          if (m_run == LOCK) m_mode = 2;
        end else begin
          m_run = 0; m_mode = 0;
        end
      end else begin
        if (ok) m_miss = 0;
        else begin
          m_err = 1;
          if (m_cnt < (1 << ECW) - 1) m_cnt++;
          m_miss++;
          if (m_miss == LOSS) begin m_miss = 0; m_mode = 0; end
        end
      end
    end
    m_prev = ab;
    m_hv   = 1;
  endtask

  task automatic check_all();
    check("phase", 32'(phase), 32'(m_phase));
    check("locked", 32'(locked), 32'(m_mode == 2));
    check("err", 32'(err), 32'(m_err));
    check("err_count", 32'(err_count), 32'(m_cnt));
`ifdef CE_PHASE_DECODER_PREDICT_EN
    check("ce_next", 32'(ce_next), (m_mode == 2) ? 32'(enc(m_exp)) : 32'd0);
`endif
  endtask

  task automatic gen(output logic [6:0] v);
    v = enc(g);
    g = (g + 1) % 64;
  endtask

  task automatic step(input logic [6:0] v);
    drv = v;
    @(posedge clk24);
    model_update(v);
    #1;
    check_all();
  endtask

  task automatic ideal(input int n);
    logic [6:0] v;
    for (int i = 0; i < n; i++) begin
      gen(v);
      step(v);
    end
  endtask

  initial begin
    logic [6:0] v;
    int reached;

    // reset state
    model_reset();
    repeat (3) @(posedge clk24);
    #1;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(err_count), 32'd0);
    reset = 1'b0;

    // ideal generator from slot 17, lock and track through wraps
    g = 17;
    ideal(260);
    check("lock_initial", 32'(locked), 32'd1);

    // single ce3 fault at slot 9
    for (int i = 0; i < 64 && g != 9; i++) ideal(1);
    gen(v); v[2] = 1'b1; step(v);
    check("ce3_err", 32'(err), 32'd1);
    check("ce3_locked", 32'(locked), 32'd1);
    ideal(20);

    // ce12 stuck-at-0 for 4 cycles: mismatches alternate, lock holds
    for (int i = 0; i < 4; i++) begin gen(v); v[0] = 1'b0; step(v); end
    ideal(4);
    check("stuck_hold", 32'(locked), 32'd1);

    // all strobes 0 from slot 40 (pipe_ab=1 so every cycle mismatches)
    for (int i = 0; i < 64 && g != 40; i++) ideal(1);
    for (int i = 0; i < 4; i++) begin
      gen(v);
      step(7'd0);
      check($sformatf("zero_lock%0d", i), 32'(locked), (i < 3) ? 32'd1 : 32'd0);
    end

    // generator slips one slot while confirming at run 40
    reached = 0;
    for (int i = 0; i < 300 && reached == 0; i++) begin
      ideal(1);
      if (m_mode == 1 && m_run == 40) reached = 1;
    end
    check("slip_reach", 32'(reached), 32'd1);
    g = (g + 1) % 64;
    ideal(1);
    check("slip_unlocked", 32'(locked), 32'd0);
    check("slip_noerr", 32'(err), 32'd0);
    ideal(200);
    check("slip_relock", 32'(locked), 32'd1);

    // 300 isolated faults drive err_count to saturation
    for (int i = 0; i < 300; i++) begin
      gen(v);
      v[$urandom_range(0, 6)] ^= 1'b1;
      step(v);
      ideal($urandom_range(1, 3));
    end
    check("sat_cnt", 32'(err_count), 32'd255);
    check("sat_locked", 32'(locked), 32'd1);

    // one-cycle reset while locked, generator keeps running
    gen(v);
    drv = v;
    reset = 1'b1;
    #1;
    check("mid_rst_phase", 32'(phase), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_cnt", 32'(err_count), 32'd0);
    @(posedge clk24);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      gen(v);
      step(v);
`ifdef CE_PHASE_DECODER_PREDICT_EN
      if (locked) check("ce_next_gen", 32'(ce_next), 32'(enc(g)));
`endif
    end
    check("rst_relock", 32'(locked), 32'd1);

    // random bus noise, then recovery
    for (int i = 0; i < 150; i++) begin
      gen(v);
      step(7'($urandom));
    end
    ideal(200);
    check("noise_relock", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
